wb_multicore_ctrl: RTL and testbench
====================================

# wb_multicore_ctrl

Wishbone-slave control block for a user area that holds `NCORES` 8-bit CPU cores, sitting between the management SoC bus and the core array inside the user project wrapper. It does three things:
- holds each core in reset or releases it;
- streams instruction words from the management CPU into a selected core's instruction memory;
- captures and masks per-core interrupts onto the three user IRQ lines.

Generalises the single-core hookup to N cores, with software-controlled boot loading.

## Interface
Parameters:
- `NCORES`, 4: number of cores, 1..8.
- `IMEM_AW`, 8: instruction-memory address width.
- `IMEM_DW`, 16: instruction word width, ≤32.
- `BASE_ADDR`, 32'h3000_0000: Wishbone base. Bits [31:8] are decoded.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic controls.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  read data.
- `core_rst_n_o`  out  NCORES  per-core active-low reset.
- `core_irq_i`  in  NCORES  per-core interrupt request, level, synchronous to `wb_clk_i`.
- `imem_we_o`  out  NCORES  one-hot instruction-memory write strobe.
- `imem_addr_o`  out  IMEM_AW  shared write address.
- `imem_data_o`  out  IMEM_DW  shared write data.
- `user_irq_o`  out  3  interrupts to the management SoC.

## Operation
Register map (byte offset from `BASE_ADDR`):
- 0x00 CTRL, RW. Bit i=1 releases core i (`core_rst_n_o[i]=1`). Reset 0.
- 0x04 IRQ_PEND, R/W1C. Bit i is set on a rising edge of `core_irq_i[i]`.
- 0x08 IRQ_MASK, RW. Reset 0.
- 0x0C IMEM_SEL, RW. Bits [2:0] are the target core. Values ≥NCORES are flagged on use.
- 0x10 IMEM_PTR, RW. Address pointer, IMEM_AW bits.
- 0x14 IMEM_DATA, WO. A write pulses `imem_we_o[IMEM_SEL]` for one cycle with `imem_addr_o=IMEM_PTR` and `imem_data_o=wbs_dat_i[IMEM_DW-1:0]`, then increments IMEM_PTR modulo 2^IMEM_AW. Reads return 0.
- 0x18 STATUS. Bit0 is the sticky ERR flag; any write clears it. Bits [15:8] are a load count, which wraps at 255 and is cleared by a write to IMEM_PTR.

Load rules:
- An IMEM_DATA write to a core whose CTRL bit is 1, or with IMEM_SEL ≥ NCORES, is rejected:
  - no strobe;
  - pointer unchanged;
  - ERR set;
  - still acked.

Byte enables:
- CTRL and IRQ_MASK honour `wbs_sel_i[0]`.
- A write with `wbs_sel_i==0` has no effect but is acked.

Decode:
- Offsets 0x1C–0xFF inside the window ack with read data 0.
- Addresses outside the window are never acked.

Interrupts:
- `user_irq_o[0] = |(IRQ_PEND & IRQ_MASK)`
- `user_irq_o[1] = ERR`
- `user_irq_o[2] = 0`
- All three are registered.

## Timing
Reset:
- `wb_rst_ni` low clears asynchronously all registers, the edge-detect flops and all outputs: ack=0, dat=0, `core_rst_n_o=0`, `imem_we_o=0`, irq=0.
- A reset in the middle of a transfer drops the transfer.

Wishbone handshake:
- `wbs_ack_o` rises the cycle after `cyc&stb` is sampled with ack low, and stays high for exactly 1 cycle. Back-to-back transfers therefore take 2 cycles each.
- Write side effects take effect on the same edge that raises ack.
- `wbs_dat_o` is valid while ack is high and is 0 otherwise.

Strobe and data outputs:
- `imem_we_o`, address and data are registered. They are valid in the ack cycle; the pointer shows the incremented value from the next cycle.

Interrupts:
- Edge capture takes 1 cycle.
- A W1C clear coinciding with a new rising edge on the same bit leaves the bit set: set wins.
- `user_irq_o` follows a PEND/MASK change by 1 cycle.
- CTRL writes reach `core_rst_n_o` in the ack cycle.

## Structure
- Package `wb_multicore_pkg`:
  - register offset localparams;
  - STATUS bit positions;
  - `BASE_ADDR` default.
- Sub-module `irq_capture`: per-bit rising-edge detect, W1C logic and mask reduction, parametrised by width. Everything else stays in the top module.

## Test plan
- Reset, then read all registers → all read 0, `core_rst_n_o=0`, no ack without `stb`.
- IMEM_SEL=2, IMEM_PTR=0xFE, write IMEM_DATA 0xA5A5, 0x1234, 0xBEEF:
  - strobes go to core 2 at addresses 0xFE, 0xFF, 0x00 (pointer wraps);
  - STATUS[15:8]=3.
- CTRL=0x4, then an IMEM_DATA write with SEL=2 → no strobe, pointer unchanged, ERR=1, `user_irq_o[1]=1`. A write to STATUS → ERR=0.
- MASK=0x1, pulse `core_irq_i[0]` → PEND=0x1 and `user_irq_o[0]` high. Write PEND=0x1 in the same cycle as a new rising edge on core 0 → PEND stays 1.
- Access to `BASE_ADDR`+0x40 → acked, reads 0. Access to `BASE_ADDR`+0x100 → never acked within 16 cycles.
- Assert `wb_rst_ni` low while ack is high during a CTRL=0xF write → outputs clear immediately and CTRL reads 0 after reset.

Source files
------------

// File: rtl/wb_multicore_pkg.sv
// Shared constants for the multicore Wishbone control block:
// register offsets, STATUS field positions and default base.
package wb_multicore_pkg;

  localparam logic [31:0] WB_BASE_DEFAULT = 32'h3000_0000;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PEND   = 8'h04;
  localparam logic [7:0] OFF_MASK   = 8'h08;
  localparam logic [7:0] OFF_SEL    = 8'h0C;
  localparam logic [7:0] OFF_PTR    = 8'h10;
  localparam logic [7:0] OFF_DATA   = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;

  localparam int ST_ERR_BIT = 0;
  localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/wb_multicore_ctrl_irq.sv
// Per-core rising-edge interrupt capture with W1C clear
// and masked OR reduction onto one registered request.
module irq_capture #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] irq,
  input  logic [W-1:0] clr,
  input  logic [W-1:0] mask,
  output logic [W-1:0] pend,
  output logic         req
);

  logic [W-1:0] irq_q;
  logic [W-1:0] rise;

  assign rise = irq & ~irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
      pend  <= '0;
      req   <= 1'b0;
    end else begin
      irq_q <= irq;
      // a new edge beats a simultaneous clear
      pend  <= (pend & ~clr) | rise;
      req   <= |(pend & mask);
    end
  end

endmodule

// File: rtl/wb_multicore_ctrl.sv
// Wishbone slave controlling reset, instruction loading
// and interrupt routing for an array of small cores.
module wb_multicore_ctrl
  import wb_multicore_pkg::*;
#(
  parameter int          NCORES    = 4,
  parameter int          IMEM_AW   = 8,
  parameter int          IMEM_DW   = 16,
  parameter logic [31:0] BASE_ADDR = WB_BASE_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [NCORES-1:0]  core_rst_n_o,
  input  logic [NCORES-1:0]  core_irq_i,
  output logic [NCORES-1:0]  imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [IMEM_DW-1:0] imem_data_o,
  output logic [2:0]         user_irq_o
);

  localparam logic [3:0] NC4 = 4'(NCORES);

  logic [NCORES-1:0]  ctrl;
  logic [NCORES-1:0]  mask;
  logic [NCORES-1:0]  pend;
  logic [NCORES-1:0]  clr;
  logic [2:0]         imem_sel;
  logic [IMEM_AW-1:0] ptr;
  logic [7:0]         cnt;
  logic               err;
  logic               err_q;
  logic               irq_any;

  logic        hit;
  logic        wr;
  logic [7:0]  off;
  logic [31:0] rdata;
  logic [7:0]  ctrl_ext;
  logic [7:0]  oh;
  logic        s_ctrl, s_pend, s_mask, s_sel;
  logic        s_ptr, s_data, s_stat;
  logic        ld, ld_bad, ld_ok;
  logic        unused_ok;

  assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
             & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr  = hit & wbs_we_i & (|wbs_sel_i);
  assign off = {wbs_adr_i[7:2], 2'b00};

  assign s_ctrl = (off == OFF_CTRL);
  assign s_pend = (off == OFF_PEND);
  assign s_mask = (off == OFF_MASK);
  assign s_sel  = (off == OFF_SEL);
  assign s_ptr  = (off == OFF_PTR);
  assign s_data = (off == OFF_DATA);
  assign s_stat = (off == OFF_STATUS);

  // loads into a running or nonexistent core are refused
  assign ctrl_ext = 8'(ctrl);
  assign oh       = 8'b1 << imem_sel;
  assign ld       = wr & s_data;
  assign ld_bad   = ({1'b0, imem_sel} >= NC4)
                  | ctrl_ext[imem_sel];
  assign ld_ok    = ld & ~ld_bad;

  assign clr = (wr & s_pend) ? wbs_dat_i[NCORES-1:0] : '0;

  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      s_ctrl: rdata = 32'(ctrl);
      s_pend: rdata = 32'(pend);
      s_mask: rdata = 32'(mask);
      s_sel:  rdata = 32'(imem_sel);
      s_ptr:  rdata = 32'(ptr);
      s_stat: begin
        rdata[ST_ERR_BIT]    = err;
        rdata[ST_CNT_LSB+:8] = cnt;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      ctrl        <= '0;
      mask        <= '0;
      imem_sel    <= '0;
      ptr         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      err_q       <= 1'b0;
      imem_we_o   <= '0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit & ~wbs_we_i) ? rdata : '0;
      imem_we_o <= '0;
      err_q     <= err;
      if (wr & s_ctrl & wbs_sel_i[0])
        ctrl <= wbs_dat_i[NCORES-1:0];
      if (wr & s_mask & wbs_sel_i[0])
        mask <= wbs_dat_i[NCORES-1:0];
      if (wr & s_sel)
        imem_sel <= wbs_dat_i[2:0];
      if (wr & s_ptr) begin
        ptr <= wbs_dat_i[IMEM_AW-1:0];
        cnt <= '0;
      end
      if (ld_ok) begin
        imem_we_o   <= oh[NCORES-1:0];
        imem_addr_o <= ptr;
        imem_data_o <= wbs_dat_i[IMEM_DW-1:0];
        ptr         <= ptr + IMEM_AW'(1);
        cnt         <= cnt + 8'd1;
      end
      if (ld & ld_bad)
        err <= 1'b1;
      if (wr & s_stat)
        err <= 1'b0;
    end
  end

  assign core_rst_n_o = ctrl;
  assign user_irq_o   = {1'b0, err_q, irq_any};

  irq_capture #(.W(NCORES)) u_irq (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .irq   (core_irq_i),
    .clr   (clr),
    .mask  (mask),
    .pend  (pend),
    .req   (irq_any)
  );

endmodule

// File: tb/tb_wb_multicore_ctrl.sv
// Directed plus random bench for wb_multicore_ctrl
// against a register-level reference model.
module tb_wb_multicore_ctrl;

  localparam int          NC   = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [NC-1:0] core_rst_n, imem_we;
  logic [NC-1:0] core_irq = '0;
  logic [NC-1:0] irq_drv = '0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [2:0]  user_irq;

  wb_multicore_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .core_rst_n_o (core_rst_n),
    .core_irq_i   (core_irq),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_data_o  (imem_data),
    .user_irq_o   (user_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NC-1:0] s_we, s_rst;
  logic [7:0]    s_addr;
  logic [15:0]   s_data;
  logic [31:0]   rd;
  logic          ak;

  // reference model state
  logic [3:0] m_ctrl, m_pend, m_mask;
  logic [2:0] m_sel;
  logic [7:0] m_ptr, m_cnt;
  logic       m_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w,
                      input logic [7:0] o,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input int lim);
    @(negedge clk);
    core_irq = irq_drv;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = BASE | 32'(o); dat = d; sel = s;
    ak = 1'b0; rd = '0;
    for (int i = 0; i < lim && !ak; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        ak = 1'b1; rd = dat_o;
        s_we = imem_we; s_rst = core_rst_n;
        s_addr = imem_addr; s_data = imem_data;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_pend = '0; m_mask = '0;
    m_sel = '0; m_ptr = '0; m_cnt = '0; m_err = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] o);
    case (o)
      8'h00: return 32'(m_ctrl);
      8'h04: return 32'(m_pend);
      8'h08: return 32'(m_mask);
      8'h0C: return 32'(m_sel);
      8'h10: return 32'(m_ptr);
      8'h18: return (32'(m_cnt) << 8) | 32'(m_err);
      default: return 32'h0;
    endcase
  endfunction

  task automatic rd_chk(input string tag, input logic [7:0] o);
    xfer(1'b0, o, 32'h0, 4'hF, 4);
    chk({tag, "_ack"}, 32'(ak), 32'd1);
    chk(tag, rd, m_read(o));
  endtask

  task automatic wr_do(input logic [7:0] o,
                       input logic [31:0] d,
                       input logic [3:0] s);
    logic       ok;
    logic [7:0] ea;
    logic [3:0] ew;
    ok = 1'b0; ea = m_ptr; ew = '0;
    if (s != 4'h0) begin
      case (o)
        8'h00: if (s[0]) m_ctrl = d[3:0];
        8'h04: m_pend = m_pend & ~d[3:0];
        8'h08: if (s[0]) m_mask = d[3:0];
        8'h0C: m_sel = d[2:0];
        8'h10: begin m_ptr = d[7:0]; m_cnt = 0; end
        8'h18: m_err = 1'b0;
        8'h14: begin
          if (m_sel >= NC || m_ctrl[m_sel[1:0]]) m_err = 1'b1;
          else begin
            ok = 1'b1; ew = 4'b1 << m_sel;
            m_ptr = m_ptr + 8'd1; m_cnt = m_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
    xfer(1'b1, o, d, s, 4);
    chk("wr_ack", 32'(ak), 32'd1);
    chk("strobe", 32'(s_we), 32'(ew));
    if (ok) begin
      chk("imem_addr", 32'(s_addr), 32'(ea));
      chk("imem_data", 32'(s_data), d & 32'hFFFF);
    end
    chk("core_rst", 32'(s_rst), 32'(m_ctrl));
  endtask

  task automatic irq_chk(input string tag);
    @(posedge clk); #1;
    chk(tag, 32'(user_irq),
        32'({1'b0, m_err, |(m_pend & m_mask)}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0]  o;
    logic [3:0]  s;
    logic [31:0] d;
    m_reset();
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_core", 32'(core_rst_n), 32'h0);
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_irq", 32'(user_irq), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); cyc = 1'b1; adr = BASE;
    repeat (3) @(posedge clk);
    #1 chk("no_stb_ack", 32'(ack), 32'd0);
    @(negedge clk); cyc = 1'b0;
    for (int i = 0; i <= 6; i++)
      rd_chk("rst_reg", 8'(i * 4));

    wr_do(8'h0C, 32'd2, 4'hF);
    wr_do(8'h10, 32'hFE, 4'hF);
    wr_do(8'h14, 32'hA5A5, 4'hF);
    @(posedge clk); #1 chk("ack_one", 32'(ack), 32'd0);
    wr_do(8'h14, 32'h1234, 4'hF);
    wr_do(8'h14, 32'hBEEF, 4'hF);
    chk("wrap_ptr", 32'(m_ptr), 32'h01);
    rd_chk("cnt3", 8'h18);
    rd_chk("ptr_wrap", 8'h10);

    wr_do(8'h00, 32'h4, 4'h1);
    wr_do(8'h14, 32'h5555, 4'hF);
    rd_chk("ptr_hold", 8'h10);
    rd_chk("err_set", 8'h18);
    irq_chk("irq_err");
    wr_do(8'h18, 32'h0, 4'hF);
    rd_chk("err_clr", 8'h18);
    wr_do(8'h00, 32'h0, 4'h1);

    wr_do(8'h08, 32'h1, 4'h1);
    @(negedge clk); core_irq = 4'h1;
    @(negedge clk); core_irq = 4'h0; irq_drv = 4'h0;
    m_pend = 4'h1;
    rd_chk("pend_set", 8'h04);
    irq_chk("irq_pend");
    irq_drv = 4'h1;
    xfer(1'b1, 8'h04, 32'h1, 4'hF, 4);
    rd_chk("set_wins", 8'h04);
    wr_do(8'h04, 32'h1, 4'hF);
    rd_chk("w1c", 8'h04);
    irq_drv = 4'h0;
    @(negedge clk); core_irq = 4'h0;

    rd_chk("hole40", 8'h40);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h100;
    ak = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (ack) ak = 1'b1;
    end
    chk("out_win", 32'(ak), 32'd0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = BASE; dat = 32'hF; sel = 4'hF;
    @(posedge clk); #1;
    chk("mid_ack", 32'(ack), 32'd1);
    chk("mid_core", 32'(core_rst_n), 32'hF);
    rst_n = 1'b0; #1;
    chk("mr_ack", 32'(ack), 32'd0);
    chk("mr_core", 32'(core_rst_n), 32'h0);
    chk("mr_irq", 32'(user_irq), 32'h0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    rd_chk("ctrl_after", 8'h00);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8)
        o = 8'($urandom_range(0, 6) * 4);
      else
        o = 8'($urandom_range(7, 63) * 4);
      case ($urandom_range(0, 3))
        0: s = 4'hF;
        1: s = 4'h1;
        2: s = 4'h0;
        default: s = 4'h2;
      endcase
      d = $urandom;
      if ($urandom_range(0, 2) != 0) wr_do(o, d, s);
      else rd_chk("rnd_rd", o);
      irq_chk("rnd_irq");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
